// File: rtl/uart_rx.sv
// Purpose: bus-attached 8N1 UART receiver with a small receive FIFO and DATA/STATUS registers.
// Latency: rd_en in cycle N -> rd_data/rd_valid in N+1; a received byte is visible the cycle after its stop-bit sample.
// Backpressure: none on the serial side; bytes arriving while the FIFO is full are dropped and flag overrun.
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames with a parity error flag at STATUS bit 4.
module uart_rx #(
  parameter int DIV   = 104,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] addr,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and falling-edge detect
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic rx_fall;

  // Two flops resolve metastability; the third copy gives the previous level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          tick;

  assign tick = (cnt == '0);

  // Bit timing: half a bit to the start-bit centre, then a full bit between sample points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fall) begin
            cnt   <= HALF_LOAD;
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_sync) begin
              // Line went back high before the start-bit centre: a glitch.
              state <= S_IDLE;
            end else begin
              cnt     <= FULL_LOAD;
              bit_idx <= '0;
              par_bad <= 1'b0;
              state   <= S_DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg   <= {rx_sync, shreg[7:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            par_bad <= (^shreg) ^ rx_sync;
            cnt     <= FULL_LOAD;
            state   <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_STOP: begin
          if (tick) begin
            // A low stop bit parks in WAIT so a break yields a single error.
            state <= rx_sync ? S_IDLE : S_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (rx_sync) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic stop_tick;
  logic push;
  logic frame_set;
  logic parity_set;

  assign stop_tick = (state == S_STOP) && tick;
  assign push      = stop_tick && rx_sync && !par_bad;
  assign frame_set = stop_tick && !rx_sync;
`ifdef UART_RX_PARITY_EN
  assign parity_set = (state == S_PARITY) && tick && ((^shreg) ^ rx_sync);
`else
  assign parity_set = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_ok;
  logic        ovr_set;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign pop     = rd_en && (addr == 2'd0) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_ok   = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  // Storage array has no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= shreg;
    end
  end

  // Pointers carry one extra wrap bit to distinguish full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags (write-1-to-clear, set wins)
  // ---------------------------------------------------------------------------
  logic overrun;
  logic frame_err;
  logic parity_err;
  logic st_wr;

  assign st_wr = wr_en && (addr == 2'd1);

  // Flags hold until software clears them; a same-cycle event keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set   | (overrun   & ~(st_wr & wr_data[3]));
      frame_err <= frame_set | (frame_err & ~(st_wr & wr_data[2]));
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity flag behaves like the other sticky flags, cleared by bit 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_set | (parity_err & ~(st_wr & wr_data[4]));
    end
  end

  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_data[7:5], wr_data[1:0]};
`else
  assign parity_err = 1'b0;

  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_data[7:4], wr_data[1:0], parity_set};
`endif

  // ---------------------------------------------------------------------------
  // Register read port
  // ---------------------------------------------------------------------------
  logic [7:0] status;
  logic       full_now;
  logic       nonempty_now;

  // Status includes a push landing this cycle so software never misses a fresh byte.
  assign full_now     = full || (push && (count == (AW + 1)'(DEPTH - 1)));
  assign nonempty_now = !empty || push;
  assign status       = {3'b000,
                         parity_err | parity_set,
                         overrun | ovr_set,
                         frame_err | frame_set,
                         full_now,
                         nonempty_now};

  // One-cycle registered read response; rd_data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        case (addr)
          2'd0:    rd_data <= empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
          2'd1:    rd_data <= status;
          default: rd_data <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rx       (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_st;
    logic [7:0] exp_dat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (DIV) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, optional even parity, stop_low low bits, then a high stop bit.
  task automatic send_frame(input logic [7:0] d, input int stop_low);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    for (int i = 0; i < stop_low; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
    check("rd_valid high", {7'd0, rd_valid}, 8'h01);
    @(negedge clk);
    check("rd_valid one cycle", {7'd0, rd_valid}, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr    = a;
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    logic [7:0] d;

    vecs[0] = '{8'hA5, 8'h01, 8'hA5};
    vecs[1] = '{8'h00, 8'h01, 8'h00};
    vecs[2] = '{8'hFF, 8'h01, 8'hFF};
    vecs[3] = '{8'h5A, 8'h01, 8'h5A};
    vecs[4] = '{8'h80, 8'h01, 8'h80};
    vecs[5] = '{8'h01, 8'h01, 8'h01};

    rst_n   = 1'b0;
    addr    = 2'd0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rx      = 1'b1;
    repeat (4) @(negedge clk);
    check("reset rd_data", rd_data, 8'h00);
    check("reset rd_valid", {7'd0, rd_valid}, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd(2'd1, d); check("reset status", d, 8'h00);

    // Single frames: status shows one byte, data pops it, status returns to empty.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].tx, 0);
      rd(2'd1, d); check("vec status", d, vecs[i].exp_st);
      rd(2'd0, d); check("vec data", d, vecs[i].exp_dat);
      rd(2'd1, d); check("vec status after pop", d, 8'h00);
    end

    // Unused addresses read zero.
    rd(2'd2, d); check("addr2 read", d, 8'h00);
    rd(2'd3, d); check("addr3 read", d, 8'h00);

    // Five frames into a four-deep FIFO: the fifth is dropped.
    for (int i = 0; i < 5; i++) send_frame(8'h31 + 8'(i), 0);
    rd(2'd1, d); check("overrun status", d, 8'h0B);
    @(negedge clk);
    addr  = 2'd0;
    rd_en = 1'b1;
    @(negedge clk);
    check("b2b first", rd_data, 8'h31);
    check("b2b first valid", {7'd0, rd_valid}, 8'h01);
    @(negedge clk);
    rd_en = 1'b0;
    check("b2b second", rd_data, 8'h32);
    check("b2b second valid", {7'd0, rd_valid}, 8'h01);
    rd(2'd0, d); check("overrun data 3", d, 8'h33);
    rd(2'd0, d); check("overrun data 4", d, 8'h34);
    rd(2'd0, d); check("empty data read", d, 8'h00);
    rd(2'd1, d); check("overrun only", d, 8'h08);
    // Read and clear STATUS in the same cycle: read sees the pre-clear value.
    @(negedge clk);
    addr    = 2'd1;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h08;
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("rd+clr pre-clear", rd_data, 8'h08);
    rd(2'd1, d); check("overrun cleared", d, 8'h00);

    // Short low glitch is rejected at the start-bit centre.
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    rd(2'd1, d); check("glitch status", d, 8'h00);

    // Stop bit held low for three bit times: one frame error, nothing pushed.
    send_frame(8'h55, 3);
    repeat (DIV) @(negedge clk);
    rd(2'd1, d); check("frame err status", d, 8'h04);
    rd(2'd0, d); check("frame err fifo empty", d, 8'h00);
    send_frame(8'h66, 0);
    rd(2'd1, d); check("after break status", d, 8'h05);
    rd(2'd0, d); check("after break data", d, 8'h66);
    wr(2'd1, 8'h04);
    rd(2'd1, d); check("frame err cleared", d, 8'h00);

    // Writes to DATA are ignored.
    wr(2'd0, 8'hFF);
    rd(2'd1, d); check("data write ignored", d, 8'h00);

    // Reset in the middle of the data bits discards the partial byte.
    @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (DIV / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rx    = 1'b1;
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    rd(2'd1, d); check("post-reset status", d, 8'h00);
    send_frame(8'h7E, 0);
    rd(2'd1, d); check("7E status", d, 8'h01);
    rd(2'd0, d); check("7E data", d, 8'h7E);
    rd(2'd1, d); check("7E empty", d, 8'h00);

`ifdef UART_RX_PARITY_EN
    // 0x03 has even ones, so a parity bit of 1 is wrong.
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 2);
    send_bit(1'b1);
    send_bit(1'b1);
    rd(2'd1, d); check("parity err status", d, 8'h10);
    wr(2'd1, 8'h10);
    rd(2'd1, d); check("parity err cleared", d, 8'h00);
    send_frame(8'h03, 0);
    rd(2'd1, d); check("parity ok status", d, 8'h01);
    rd(2'd0, d); check("parity ok data", d, 8'h03);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
